// File: rtl/seg7_scan_driver.sv
// Avalon-MM 4-digit multiplexed 7-segment scanner with anti-ghost blanking.
// Display contents come from shadow registers that reload only at frame boundaries.
module seg7_scan_driver #(
   parameter int unsigned DIGIT_PERIOD   = 50000,
   parameter int unsigned BLANK_CYCLES   = 500,
   parameter bit          SEL_ACTIVE_LOW = 1'b1,
   parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  avs_address,
   input  logic        avs_write,
   input  logic [31:0] avs_writedata,
   input  logic        avs_read,
   output logic [31:0] avs_readdata,
   output logic [3:0]  display_select,
   output logic [7:0]  display_segment
);

   localparam int unsigned    CntW     = (DIGIT_PERIOD > 1) ? $clog2(DIGIT_PERIOD) : 1;
   localparam logic [CntW-1:0] CntLast  = CntW'(DIGIT_PERIOD - 1);
   localparam logic [CntW-1:0] CntBlank = CntW'(BLANK_CYCLES);
   localparam logic [3:0]     SelOff   = SEL_ACTIVE_LOW ? 4'hF : 4'h0;
   localparam logic [7:0]     SegOff   = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

   function automatic logic [6:0] hex7(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0:    s = 7'h3F;
         4'h1:    s = 7'h06;
         4'h2:    s = 7'h5B;
         4'h3:    s = 7'h4F;
         4'h4:    s = 7'h66;
         4'h5:    s = 7'h6D;
         4'h6:    s = 7'h7D;
         4'h7:    s = 7'h07;
         4'h8:    s = 7'h7F;
         4'h9:    s = 7'h6F;
         4'hA:    s = 7'h77;
         4'hB:    s = 7'h7C;
         4'hC:    s = 7'h39;
         4'hD:    s = 7'h5E;
         4'hE:    s = 7'h79;
         default: s = 7'h71;
      endcase
      return s;
   endfunction

   logic [15:0]     data_q, data_d, sh_data_q, sh_data_d;
   logic [8:0]      ctrl_q, ctrl_d, sh_ctrl_q, sh_ctrl_d;
   logic [31:0]     raw_q, raw_d, sh_raw_q, sh_raw_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [1:0]      digit_q, digit_d;
   logic            pending_q, pending_d;
   logic [31:0]     rdata_q, rdata_d;
   logic [3:0]      sel_q, sel_d;
   logic [7:0]      seg_q, seg_d;

   logic       slot_end, frame_end, wr_live;
   logic [3:0] nib, sel_on, dp_mask;
   logic [7:0] pattern;

   always_comb begin
      data_d    = data_q;
      ctrl_d    = ctrl_q;
      raw_d     = raw_q;
      wr_live   = avs_write && (avs_address != 2'd3);
      if (avs_write) begin
         case (avs_address)
            2'd0:    data_d = avs_writedata[15:0];
            2'd1:    ctrl_d = avs_writedata[8:0];
            2'd2:    raw_d  = avs_writedata;
            default: ;
         endcase
      end

      slot_end  = (cnt_q == CntLast);
      frame_end = slot_end && (digit_q == 2'd3);
      cnt_d     = slot_end ? '0 : cnt_q + CntW'(1);
      digit_d   = slot_end ? digit_q + 2'd1 : digit_q;

      // Shadows sample the pre-write live values, so a boundary-cycle write waits a frame.
      sh_data_d = frame_end ? data_q : sh_data_q;
      sh_ctrl_d = frame_end ? ctrl_q : sh_ctrl_q;
      sh_raw_d  = frame_end ? raw_q  : sh_raw_q;
      pending_d = wr_live ? 1'b1 : (frame_end ? 1'b0 : pending_q);

      rdata_d = rdata_q;
      if (avs_read) begin
         case (avs_address)
            2'd0:    rdata_d = {16'h0, data_q};
            2'd1:    rdata_d = {23'h0, ctrl_q};
            2'd2:    rdata_d = raw_q;
            default: rdata_d = {29'h0, pending_q, digit_q};
         endcase
      end

      nib     = sh_data_q[{digit_q, 2'b00} +: 4];
      dp_mask = sh_ctrl_q[7:4];
      pattern = sh_ctrl_q[8] ? sh_raw_q[{digit_q, 3'b000} +: 8]
                             : {dp_mask[digit_q], hex7(nib)};
      sel_on  = sh_ctrl_q[3:0] & (4'b0001 << digit_q);

      if (cnt_q < CntBlank) begin
         sel_d = SelOff;
         seg_d = SegOff;
      end else begin
         sel_d = SEL_ACTIVE_LOW ? ~sel_on : sel_on;
         seg_d = SEG_ACTIVE_LOW ? ~pattern : pattern;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_q    <= '0;
         ctrl_q    <= 9'h00F;
         raw_q     <= '0;
         sh_data_q <= '0;
         sh_ctrl_q <= 9'h00F;
         sh_raw_q  <= '0;
         cnt_q     <= '0;
         digit_q   <= '0;
         pending_q <= 1'b0;
         rdata_q   <= '0;
         sel_q     <= SelOff;
         seg_q     <= SegOff;
      end else begin
         data_q    <= data_d;
         ctrl_q    <= ctrl_d;
         raw_q     <= raw_d;
         sh_data_q <= sh_data_d;
         sh_ctrl_q <= sh_ctrl_d;
         sh_raw_q  <= sh_raw_d;
         cnt_q     <= cnt_d;
         digit_q   <= digit_d;
         pending_q <= pending_d;
         rdata_q   <= rdata_d;
         sel_q     <= sel_d;
         seg_q     <= seg_d;
      end
   end

   assign avs_readdata    = rdata_q;
   assign display_select  = sel_q;
   assign display_segment = seg_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (8-cycle slots, 2 blank cycles, active-low pins).
module tb_seg7_scan_driver;

   localparam int Slot  = 8;
   localparam int Blank = 2;
   localparam int Frame = 4 * Slot;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  avs_address = '0;
   logic        avs_write = 1'b0;
   logic [31:0] avs_writedata = '0;
   logic        avs_read = 1'b0;
   logic [31:0] avs_readdata;
   logic [3:0]  display_select;
   logic [7:0]  display_segment;

   always #5 clk = ~clk;

   seg7_scan_driver #(
      .DIGIT_PERIOD  (Slot),
      .BLANK_CYCLES  (Blank),
      .SEL_ACTIVE_LOW(1'b1),
      .SEG_ACTIVE_LOW(1'b1)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .avs_address    (avs_address),
      .avs_write      (avs_write),
      .avs_writedata  (avs_writedata),
      .avs_read       (avs_read),
      .avs_readdata   (avs_readdata),
      .display_select (display_select),
      .display_segment(display_segment)
   );

   typedef struct {
      logic [1:0]  addr;
      logic [31:0] wdata;
      logic [31:0] rdback;
      logic [15:0] xsel;  // active-part select per digit, digit k at [4k+:4]
      logic [31:0] xseg;  // active-low segments per digit, digit k at [8k+:8]
   } vec_t;

   vec_t        vecs[8];
   logic [31:0] rd_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s at cyc %0d: got %h, want %h", name, cyc, act, want);
      end
   endtask

   task automatic drive_write(input logic [1:0] a, input logic [31:0] d);
      avs_address   = a;
      avs_writedata = d;
      avs_write     = 1'b1;
   endtask

   task automatic drive_read(input logic [1:0] a, input logic [31:0] want);
      avs_address = a;
      avs_read    = 1'b1;
      rd_q.push_back(want);
   endtask

   // One clock; a read sampled at this edge is scored against the queue head.
   task automatic tick();
      logic [31:0] want;
      @(posedge clk);
      #1;
      cyc++;
      if (avs_read) begin
         if (rd_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rd_queue at cyc %0d: got empty queue, want an entry", cyc);
         end else begin
            want = rd_q.pop_front();
            cmp("readdata", avs_readdata, want);
         end
      end
      avs_read  = 1'b0;
      avs_write = 1'b0;
   endtask

   // Checks every pin sample of frame k; optional write at slot wj, readback at wj+1,
   // and a STAT read at slot 11 expecting pending=xpend, digit 1.
   task automatic run_frame(input int k, input logic [15:0] xsel, input logic [31:0] xseg,
                            input bit wr, input int wj, input logic [1:0] wa,
                            input logic [31:0] wd, input logic [31:0] rb, input bit xpend);
      int         m, d, c;
      logic [3:0] es;
      logic [7:0] eg;
      if (cyc != k * Frame) begin
         $display("FAIL frame_align: got cyc %0d, want %0d", cyc, k * Frame);
         $fatal(1);
      end
      for (int j = 1; j <= Frame; j++) begin
         if (wr && j == wj) drive_write(wa, wd);
         if (wr && j == wj + 1) drive_read(wa, rb);
         if (j == 11) drive_read(2'd3, {29'h0, xpend, 2'd1});
         tick();
         m = cyc - 1;
         d = (m / Slot) % 4;
         c = m % Slot;
         if (c < Blank) begin
            es = 4'hF;
            eg = 8'hFF;
         end else begin
            es = xsel[4*d +: 4];
            eg = xseg[8*d +: 8];
         end
         cmp("select", {28'h0, display_select}, {28'h0, es});
         if (c < Blank || es != 4'hF) cmp("segment", {24'h0, display_segment}, {24'h0, eg});
      end
   endtask

   initial begin
      logic [15:0] psel;
      logic [31:0] pseg;

      vecs[0] = '{2'd0, 32'h0000_1234, 32'h0000_1234, 16'h7BDE, 32'hF9A4_B099};
      vecs[1] = '{2'd1, 32'h0000_0015, 32'h0000_0015, 16'hFBFE, 32'hF9A4_B019};
      vecs[2] = '{2'd2, 32'h80FF_0049, 32'h80FF_0049, 16'hFBFE, 32'hF9A4_B019};
      vecs[3] = '{2'd1, 32'h0000_010F, 32'h0000_010F, 16'h7BDE, 32'h7F00_FFB6};
      vecs[4] = '{2'd0, 32'h0000_ABCD, 32'h0000_ABCD, 16'h7BDE, 32'h7F00_FFB6};
      vecs[5] = '{2'd1, 32'h0000_000F, 32'h0000_000F, 16'h7BDE, 32'h8883_C6A1};
      vecs[6] = '{2'd0, 32'hFFFF_5EF0, 32'h0000_5EF0, 16'h7BDE, 32'h9286_8EC0};
      vecs[7] = '{2'd0, 32'h0000_6789, 32'h0000_6789, 16'h7BDE, 32'h82F8_8090};

      repeat (3) @(posedge clk);
      #1;
      cmp("reset_select", {28'h0, display_select}, 32'h0000_000F);
      cmp("reset_segment", {24'h0, display_segment}, 32'h0000_00FF);
      cmp("reset_readdata", avs_readdata, 32'h0);
      reset_n = 1'b1;
      cyc     = 0;

      psel = 16'h7BDE;
      pseg = 32'hC0C0_C0C0;
      run_frame(0, psel, pseg, 1'b0, 0, 2'd0, 32'h0, 32'h0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         run_frame(2*i + 1, psel, pseg, 1'b1, 5, vecs[i].addr, vecs[i].wdata,
                   vecs[i].rdback, 1'b1);
         run_frame(2*i + 2, vecs[i].xsel, vecs[i].xseg, 1'b0, 0, 2'd0, 32'h0, 32'h0, 1'b0);
         psel = vecs[i].xsel;
         pseg = vecs[i].xseg;
      end

      // Write landing exactly on the frame boundary: shown one frame late, pending survives.
      run_frame(17, psel, pseg, 1'b1, 32, 2'd0, 32'h0000_2468, 32'h0, 1'b0);
      run_frame(18, psel, pseg, 1'b0, 0, 2'd0, 32'h0, 32'h0, 1'b1);
      pseg = 32'hA499_8280;
      run_frame(19, psel, pseg, 1'b0, 0, 2'd0, 32'h0, 32'h0, 1'b0);

      // STAT is read-only and a write to it must not raise pending.
      run_frame(20, psel, pseg, 1'b1, 5, 2'd3, 32'hFFFF_FFFF, 32'h0, 1'b0);
      run_frame(21, psel, pseg, 1'b0, 0, 2'd0, 32'h0, 32'h0, 1'b0);

      // Same-cycle read/write returns the old value; readdata holds while idle.
      drive_write(2'd0, 32'h0000_1357);
      drive_read(2'd0, 32'h0000_2468);
      tick();
      tick();
      cmp("readdata_hold", avs_readdata, 32'h0000_2468);
      drive_read(2'd0, 32'h0000_1357);
      tick();
      drive_read(2'd1, 32'h0000_000F);
      tick();
      drive_read(2'd2, 32'h80FF_0049);
      tick();

      // Asynchronous reset in the middle of digit 2's lit window.
      while (cyc % Frame != 20) tick();
      cmp("pre_reset_select", {28'h0, display_select}, 32'h0000_000B);
      #2;
      reset_n = 1'b0;
      #1;
      cmp("async_reset_select", {28'h0, display_select}, 32'h0000_000F);
      cmp("async_reset_segment", {24'h0, display_segment}, 32'h0000_00FF);
      cmp("async_reset_readdata", avs_readdata, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      cyc     = 0;
      drive_read(2'd0, 32'h0);
      tick();
      drive_read(2'd1, 32'h0000_000F);
      tick();
      drive_read(2'd2, 32'h0);
      tick();
      drive_read(2'd3, 32'h0);
      tick();

      if (rd_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL rd_queue_drain: got %0d outstanding reads, want 0", rd_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
